// File: rtl/mem_sched.sv
// mem_sched: memory access scheduler between the CPU, the front-panel
// load/check logic and a single-ported program/data store.
//
// Every access runs IDLE -> SETUP -> STROBE -> CAPTURE, so the store sees
// stable address/data for one cycle before and one cycle after each
// one-cycle strobe. The active owner is selected by cpustate:
//   11 RUN   : CPU bus requests only
//   01 IN    : panel key press writes sw to {11'b0, panel_cnt}
//   10 CHECK : entry auto-reads address 0, each press reads the next address
//   00       : no new transactions
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cpustate[1:0]               owner select
//   key                         panel button, active-low, asynchronous
//   sw[7:0]                     panel switches (IN write data)
//   cpu_req/we/addr/wdata       CPU request, held until cpu_ack
//   cpu_ack/rdata/err           CPU completion pulse, read data, reject flag
//   mem_addr/wdata/read/write   store interface (all registered)
//   mem_rdata                   store read data
//   panel_cnt[4:0]              panel address counter
//   check_data[7:0]             last byte read in CHECK
//   busy                        FSM not in IDLE
module mem_sched #(
  parameter int DB_CYCLES = 4,
  parameter int ROM_TOP   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cpustate,
  input  logic        key,
  input  logic [7:0]  sw,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata,
  output logic [4:0]  panel_cnt,
  output logic [7:0]  check_data,
  output logic        busy
);

  localparam logic [1:0] CS_IN    = 2'b01;
  localparam logic [1:0] CS_CHECK = 2'b10;
  localparam logic [1:0] CS_RUN   = 2'b11;
  localparam int         DBW      = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_CAPTURE} state_t;
  typedef enum logic [2:0] {OP_CPU_RD, OP_CPU_WR, OP_CPU_REJ, OP_PNL_WR, OP_PNL_RD} op_t;

  // key synchronizer and debouncer
  logic           key_s1_q, key_s1_d;
  logic           key_s2_q, key_s2_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           armed_q, armed_d;
  logic           press;

  // request bookkeeping
  logic       panel_pend_q, panel_pend_d;
  logic       auto_rd_q, auto_rd_d;
  logic [1:0] cs_prev_q, cs_prev_d;

  // transaction FSM and registered outputs
  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [4:0]  cnt_upd_q, cnt_upd_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [4:0]  panel_cnt_q, panel_cnt_d;
  logic [7:0]  check_data_q, check_data_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        cpu_err_q, cpu_err_d;
  logic        busy_q, busy_d;

  logic       panel_own;
  logic       entry_chk;
  logic       entry_in;
  logic [4:0] cnt_inc;

  assign panel_own = (cpustate == CS_IN) || (cpustate == CS_CHECK);
  assign entry_chk = (cpustate == CS_CHECK) && (cs_prev_q != CS_CHECK);
  assign entry_in  = (cpustate == CS_IN) && (cs_prev_q != CS_IN);
  assign cnt_inc   = panel_cnt_q + 5'd1;  // 31 wraps to 0

  // Debounce: while armed, count consecutive low samples and fire once;
  // while disarmed, count consecutive high samples to re-arm.
  always_comb begin
    key_s1_d = key;
    key_s2_d = key_s1_q;
    db_cnt_d = db_cnt_q;
    armed_d  = armed_q;
    press    = 1'b0;
    if (armed_q) begin
      if (!key_s2_q) begin
        if (db_cnt_q == DB_LAST) begin
          press    = 1'b1;
          armed_d  = 1'b0;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_d = '0;
      end
    end else begin
      if (key_s2_q) begin
        if (db_cnt_q == DB_LAST) begin
          armed_d  = 1'b1;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_d = '0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_upd_d    = cnt_upd_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    panel_cnt_d  = panel_cnt_q;
    check_data_d = check_data_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_ack_d    = 1'b0;
    cpu_err_d    = 1'b0;
    busy_d       = busy_q;
    cs_prev_d    = cpustate;
    auto_rd_d    = auto_rd_q;

    // one-deep press latch; a press arriving while one is pending is dropped
    panel_pend_d = panel_pend_q;
    if (press && panel_own) panel_pend_d = 1'b1;
    if (entry_chk) auto_rd_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        // the ack cycle never accepts, so a held cpu_req is not re-taken
        if (!cpu_ack_q) begin
          if (cpustate == CS_RUN && cpu_req) begin
            state_d    = S_SETUP;
            busy_d     = 1'b1;
            mem_addr_d = cpu_addr;
            if (cpu_we) begin
              mem_wdata_d = cpu_wdata;
              op_d        = (cpu_addr < 16'(ROM_TOP)) ? OP_CPU_REJ : OP_CPU_WR;
            end else begin
              op_d = OP_CPU_RD;
            end
          end else if (!entry_chk && !entry_in) begin
            // entry cycles are skipped so panel_cnt has already been cleared
            if (cpustate == CS_CHECK && auto_rd_q) begin
              state_d    = S_SETUP;
              busy_d     = 1'b1;
              op_d       = OP_PNL_RD;
              mem_addr_d = 16'h0000;
              cnt_upd_d  = 5'd0;
              auto_rd_d  = 1'b0;
            end else if (cpustate == CS_CHECK && panel_pend_q) begin
              state_d      = S_SETUP;
              busy_d       = 1'b1;
              op_d         = OP_PNL_RD;
              mem_addr_d   = {11'b0, cnt_inc};
              cnt_upd_d    = cnt_inc;
              panel_pend_d = 1'b0;
            end else if (cpustate == CS_IN && panel_pend_q) begin
              state_d      = S_SETUP;
              busy_d       = 1'b1;
              op_d         = OP_PNL_WR;
              mem_addr_d   = {11'b0, panel_cnt_q};
              mem_wdata_d  = sw;
              cnt_upd_d    = cnt_inc;
              panel_pend_d = 1'b0;
            end
          end
        end
      end
      S_SETUP: begin
        state_d     = S_STROBE;
        mem_read_d  = (op_q == OP_CPU_RD) || (op_q == OP_PNL_RD);
        // rejected writes keep the full timing but never raise mem_write
        mem_write_d = (op_q == OP_CPU_WR) || (op_q == OP_PNL_WR);
      end
      S_STROBE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        unique case (op_q)
          OP_CPU_RD: begin
            cpu_rdata_d = mem_rdata;
            cpu_ack_d   = 1'b1;
          end
          OP_CPU_WR: cpu_ack_d = 1'b1;
          OP_CPU_REJ: begin
            cpu_ack_d = 1'b1;
            cpu_err_d = 1'b1;
          end
          OP_PNL_WR: panel_cnt_d = cnt_upd_q;
          OP_PNL_RD: begin
            panel_cnt_d  = cnt_upd_q;
            check_data_d = mem_rdata;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    // owner change wins over any in-flight counter update
    if (entry_chk || entry_in) panel_cnt_d = 5'd0;
    if (!panel_own) panel_pend_d = 1'b0;
    if (cpustate != CS_CHECK) auto_rd_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_q     <= 1'b0;
      key_s2_q     <= 1'b0;
      db_cnt_q     <= '0;
      armed_q      <= 1'b0;
      panel_pend_q <= 1'b0;
      auto_rd_q    <= 1'b0;
      cs_prev_q    <= 2'b00;
      state_q      <= S_IDLE;
      op_q         <= OP_CPU_RD;
      cnt_upd_q    <= 5'd0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 8'h00;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      panel_cnt_q  <= 5'd0;
      check_data_q <= 8'h00;
      cpu_rdata_q  <= 8'h00;
      cpu_ack_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      key_s1_q     <= key_s1_d;
      key_s2_q     <= key_s2_d;
      db_cnt_q     <= db_cnt_d;
      armed_q      <= armed_d;
      panel_pend_q <= panel_pend_d;
      auto_rd_q    <= auto_rd_d;
      cs_prev_q    <= cs_prev_d;
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_upd_q    <= cnt_upd_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      panel_cnt_q  <= panel_cnt_d;
      check_data_q <= check_data_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_err_q    <= cpu_err_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_err    = cpu_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign panel_cnt  = panel_cnt_q;
  assign check_data = check_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_sched.sv
// Bench for mem_sched: a byte store answers the DUT's strobes, and a
// reference image of memory plus a panel-address counter predict every
// result from the block's rules.
module tb_mem_sched;

  logic        clk;
  logic        reset;
  logic [1:0]  cpustate;
  logic        key;
  logic [7:0]  sw;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic [4:0]  panel_cnt;
  logic [7:0]  check_data;
  logic        busy;

  mem_sched #(.DB_CYCLES(4), .ROM_TOP(32)) dut (
    .clk(clk), .reset(reset), .cpustate(cpustate), .key(key), .sw(sw),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .panel_cnt(panel_cnt), .check_data(check_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // store: first 256 bytes, loaded once from seed_mem during the first reset
  logic [7:0] seed_mem [0:255];
  logic [7:0] store    [0:255];
  logic [7:0] exp_mem  [0:255];
  logic       loaded = 1'b0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic [15:0] last_wa = 16'h0;
  logic [7:0]  last_wd = 8'h0;

  assign mem_rdata = store[mem_addr[7:0]];

  always @(posedge clk) begin
    if (reset && !loaded) begin
      for (int i = 0; i < 256; i++) store[i] <= seed_mem[i];
      loaded <= 1'b1;
    end
    if (mem_write) begin
      store[mem_addr[7:0]] <= mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wdata;
    end
    if (mem_read) rd_cnt <= rd_cnt + 1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // key low for lo cycles, then high long enough to finish and re-arm
  task automatic key_pulse(input int lo);
    @(negedge clk);
    key = 1'b0;
    repeat (lo) @(negedge clk);
    key = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // one CPU transaction; cycle k is the k-th negedge after the accept edge.
  // sw_cyc > 0 switches cpustate to CHECK in that cycle.
  task automatic cpu_txn(input logic we, input logic [15:0] a, input logic [7:0] d,
                         input int sw_cyc, output int ack_cyc, output int wr_cyc,
                         output int nwr, output logic err, output logic [7:0] rd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    ack_cyc = -1; wr_cyc = -1; nwr = 0; err = 1'b0; rd = 8'h00;
    for (int k = 1; k <= 12 && ack_cyc < 0; k++) begin
      @(negedge clk);
      if (mem_write) begin nwr++; wr_cyc = k; end
      if (k == sw_cyc) cpustate = 2'b10;
      if (cpu_ack) begin
        ack_cyc = k; err = cpu_err; rd = cpu_rdata; cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int w0, r0;
    int ack_c, wr_c, nw;
    logic er;
    logic [7:0] rd, d, v;
    logic [15:0] a;
    logic we;
    logic [7:0] in_vals [0:2];
    int ack_seen;

    in_vals[0] = 8'hA0; in_vals[1] = 8'h01; in_vals[2] = 8'hA4;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      seed_mem[i] = v;
      exp_mem[i]  = v;
    end
    reset = 1'b1; cpustate = 2'b00; key = 1'b1; sw = 8'h00;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_ack", {31'b0, cpu_ack}, 0);
    chk("rst_err", {31'b0, cpu_err}, 0);
    chk("rst_rdata", {24'b0, cpu_rdata}, 0);
    chk("rst_maddr", {16'b0, mem_addr}, 0);
    chk("rst_mwdata", {24'b0, mem_wdata}, 0);
    chk("rst_strobes", {30'b0, mem_read, mem_write}, 0);
    chk("rst_pcnt", {27'b0, panel_cnt}, 0);
    chk("rst_chkdata", {24'b0, check_data}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // IN load: three presses write sw to consecutive panel addresses
    cpustate = 2'b01;
    pc = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sw = in_vals[i];
      w0 = wr_cnt;
      key_pulse(4);
      chk("in_wrcnt", wr_cnt, w0 + 1);
      chk("in_waddr", {16'b0, last_wa}, pc);
      chk("in_wdata", {24'b0, last_wd}, {24'b0, in_vals[i]});
      exp_mem[pc] = in_vals[i];
      pc = (pc + 1) % 32;
      chk("in_pcnt", {27'b0, panel_cnt}, pc);
    end
    // 2-cycle glitch is not a press
    w0 = wr_cnt;
    sw = 8'h5C;
    key_pulse(2);
    chk("glitch_wrcnt", wr_cnt, w0);
    chk("glitch_pcnt", {27'b0, panel_cnt}, 3);

    // CHECK: auto-read of address 0, then each press reads the next address
    cpustate = 2'b10;
    repeat (10) @(negedge clk);
    pc = 0;
    chk("chk_auto_pcnt", {27'b0, panel_cnt}, 0);
    chk("chk_auto_data", {24'b0, check_data}, 32'hA0);
    key_pulse(4);
    pc = 1;
    chk("chk_p1_pcnt", {27'b0, panel_cnt}, 1);
    chk("chk_p1_data", {24'b0, check_data}, 32'h01);
    for (int i = 0; i < 31; i++) begin
      key_pulse(4);
      pc = (pc + 1) % 32;
      chk("chk_walk_pcnt", {27'b0, panel_cnt}, pc);
      chk("chk_walk_data", {24'b0, check_data}, {24'b0, exp_mem[pc]});
    end
    chk("chk_wrap_pcnt", {27'b0, panel_cnt}, 0);
    key_pulse(4);
    pc = 1;
    chk("chk_after_wrap", {24'b0, check_data}, {24'b0, exp_mem[1]});

    // RUN: directed CPU write/read
    cpustate = 2'b11;
    repeat (3) @(negedge clk);
    cpu_txn(1'b1, 16'h0040, 8'h5A, 0, ack_c, wr_c, nw, er, rd);
    exp_mem[8'h40] = 8'h5A;
    chk("wr_ack_cyc", ack_c, 4);
    chk("wr_strobe_cyc", wr_c, 2);
    chk("wr_strobe_cnt", nw, 1);
    chk("wr_err", {31'b0, er}, 0);
    chk("wr_addr", {16'b0, last_wa}, 32'h40);
    chk("wr_data", {24'b0, last_wd}, 32'h5A);
    cpu_txn(1'b0, 16'h0040, 8'h00, 0, ack_c, wr_c, nw, er, rd);
    chk("rd_ack_cyc", ack_c, 4);
    chk("rd_data", {24'b0, rd}, 32'h5A);
    chk("rd_strobe_cnt", nw, 0);

    // protected write
    cpu_txn(1'b1, 16'h0005, 8'hFF, 0, ack_c, wr_c, nw, er, rd);
    chk("prot_ack_cyc", ack_c, 4);
    chk("prot_err", {31'b0, er}, 1);
    chk("prot_no_write", nw, 0);
    cpu_txn(1'b0, 16'h0005, 8'h00, 0, ack_c, wr_c, nw, er, rd);
    chk("prot_readback", {24'b0, rd}, {24'b0, exp_mem[5]});

    // random CPU traffic over both regions
    for (int i = 0; i < 24; i++) begin
      a  = 16'($urandom_range(0, 95));
      we = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      r0 = rd_cnt;
      cpu_txn(we, a, d, 0, ack_c, wr_c, nw, er, rd);
      chk("rnd_ack_cyc", ack_c, 4);
      chk("rnd_err", {31'b0, er}, {31'b0, (we && a < 32)});
      chk("rnd_nwr", nw, (we && a >= 32) ? 1 : 0);
      if (we) begin
        if (a >= 32) exp_mem[a[7:0]] = d;
      end else begin
        chk("rnd_rdata", {24'b0, rd}, {24'b0, exp_mem[a[7:0]]});
        chk("rnd_rdstrobe", rd_cnt, r0 + 1);
      end
    end

    // key press while the CPU owns the store is ignored
    w0 = wr_cnt; r0 = rd_cnt;
    key_pulse(4);
    chk("run_key_wr", wr_cnt, w0);
    chk("run_key_rd", rd_cnt, r0);
    chk("run_key_pcnt", {27'b0, panel_cnt}, pc);

    // switch to CHECK during the strobe: CPU write completes, then auto-read
    d = 8'($urandom);
    cpu_txn(1'b1, 16'h0050, d, 2, ack_c, wr_c, nw, er, rd);
    exp_mem[8'h50] = d;
    chk("sw_ack_cyc", ack_c, 4);
    chk("sw_strobe_cnt", nw, 1);
    chk("sw_wdata", {24'b0, last_wd}, {24'b0, d});
    repeat (12) @(negedge clk);
    pc = 0;
    chk("sw_auto_pcnt", {27'b0, panel_cnt}, 0);
    chk("sw_auto_data", {24'b0, check_data}, {24'b0, exp_mem[0]});

    // reset during STROBE: strobes drop, no ack follows
    cpustate = 2'b11;
    repeat (3) @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0060; cpu_wdata = 8'h33;
    repeat (2) @(negedge clk);
    chk("mid_strobe", {31'b0, mem_write}, 1);
    chk("mid_busy", {31'b0, busy}, 1);
    reset = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    reset = 1'b0;
    chk("mid_rst_strobe", {31'b0, mem_write}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    ack_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack) ack_seen++;
    end
    chk("mid_rst_noack", ack_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sched.md
# mem_sched

Memory access scheduler that sits between the CPU, the front-panel load/check logic and the single-ported program/data store. It turns CPU bus requests and debounced panel key presses into correctly sequenced read/write strobes with stable address and data. It owns the panel address counter and blocks illegal writes into the 32-byte program region. Only one owner drives the store at any time, selected by `cpustate`.

## Interface
- `DB_CYCLES`, 4: key must be sampled stable low this many consecutive cycles to count as a press.
- `ROM_TOP`, 32: addresses below this are program store; CPU writes there are rejected.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `cpustate` in 2: 01 IN, 10 CHECK, 11 RUN, 00 idle.
- `key` in 1: panel button A1, active-low, asynchronous.
- `sw` in 8: panel switches SW7-SW0, the data to store in IN.
- `cpu_req` in 1: CPU request; held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read; qualified by `cpu_req`.
- `cpu_addr` in 16: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 8: read data; valid while `cpu_ack`=1, held until the next read.
- `cpu_err` out 1: pulses with `cpu_ack` when a write was rejected.
- `mem_addr` out 16: address to the store.
- `mem_wdata` out 8: write data to the store.
- `mem_read` out 1: read strobe to the store.
- `mem_write` out 1: write strobe to the store.
- `mem_rdata` in 8: data returned by the store.
- `panel_cnt` out 5: current panel address.
- `check_data` out 8: last byte read in CHECK.
- `busy` out 1: FSM not in IDLE.

## Operation
- **Key handling**
  - 2-FF synchronizer, then a stability counter.
  - A press is registered once, after `DB_CYCLES` consecutive low samples.
  - Re-arm only after `DB_CYCLES` consecutive high samples.
  - A registered press sets `panel_pend`, one deep; further presses while pending are dropped.
- **Ownership**
  - RUN: CPU only.
  - IN/CHECK: panel only.
  - 00: no new transactions.
  - A pending request from a non-owner is ignored; `panel_pend` is cleared whenever `cpustate` is not IN/CHECK.
- **FSM states**
  - IDLE: accept a request and register `mem_addr`/`mem_wdata`.
  - SETUP: all strobes low.
  - STROBE: `mem_read` or `mem_write` high for exactly one cycle.
  - CAPTURE: strobes low; read data latched at the end of this cycle.
  - Transitions: IDLE->SETUP on accept; SETUP->STROBE->CAPTURE->IDLE unconditionally.
- **IN press**
  - Write `sw` to address {11'b0, `panel_cnt`}.
  - `panel_cnt` increments on CAPTURE exit; 31 wraps to 0.
- **CHECK**
  - On entry (`cpustate` changes to 10 from another value), `panel_cnt` clears to 0 and a read of address 0 is auto-queued.
  - Each press increments `panel_cnt` (with wrap), then reads the new address.
  - `check_data` loads from `mem_rdata` on CAPTURE exit.
- **Entry into IN**: `panel_cnt` clears to 0.
- **CPU read**: `cpu_rdata` loads on CAPTURE exit; `cpu_ack` pulses the next cycle.
- **CPU write**
  - If `cpu_addr` < `ROM_TOP`, the FSM still runs SETUP/STROBE/CAPTURE with `mem_write` held low.
  - `cpu_ack` and `cpu_err` then pulse together.
- **State change mid-transaction**: a started transaction always completes with full strobe timing, and its ack/update is still delivered. A cancelled state change does not truncate strobes.

## Timing
- **Reset**: all outputs are 0, FSM in IDLE, `panel_cnt`=0, `panel_pend`=0, `check_data`=0, `cpu_rdata`=0.
- **CPU latency**: `cpu_req` sampled high in IDLE at edge 0 gives:
  - SETUP in cycle 1;
  - strobe in cycle 2;
  - CAPTURE in cycle 3;
  - `cpu_ack` in cycle 4 (FSM back in IDLE).
- **Acknowledge cycle**
  - No accept occurs in the ack cycle.
  - The requester must drop `cpu_req` in the ack cycle; if `cpu_req` is still high the cycle after, it is a new request.
  - Minimum request spacing is therefore 5 cycles.
- **Panel latency**: press registered at edge N gives the strobe at cycle N+3; `panel_cnt`/`check_data` update at edge N+4.
- **Address/data stability**: `mem_addr` and `mem_wdata` are stable from SETUP through CAPTURE. The store sees at least one setup and one hold cycle around each strobe edge.
- **Reset mid-transaction**: strobes drop in the next cycle, no ack is issued, and the operation is lost.

## Test plan
- **Reset**: assert `reset` for 2 cycles -> all outputs 0, `busy`=0.
- **IN load**: `cpustate`=01; `key` low for 4 cycles, 3 times, with `sw`=A0,01,A4.
  - Writes occur to addresses 0,1,2 with those bytes.
  - `panel_cnt`=3.
  - A 2-cycle glitch on `key` produces no write.
- **CHECK**: `cpustate`=10 after the load above.
  - Auto-read gives `check_data`=A0.
  - One press gives `panel_cnt`=1, `check_data`=01.
  - 31 further presses wrap `panel_cnt` to 0.
- **CPU write/read**: `cpustate`=11; write 5A to 0x0040, then read 0x0040.
  - `mem_write` pulses once in cycle 2.
  - `cpu_ack` arrives in cycle 4 of each transaction.
  - `cpu_rdata`=5A.
- **Protected write**: write FF to 0x0005 -> `mem_write` stays 0; `cpu_ack`=`cpu_err`=1 in cycle 4; address 5 unchanged.
- **Ownership**
  - A key press in RUN: ignored, no panel access.
  - `cpustate` switched 11->10 during STROBE: the CPU transaction still acks, then the CHECK auto-read follows.
